// File: rtl/tf_rom_seq.sv
// Twiddle-factor RAM with a built-in read sequencer. The memory is preloaded while idle,
// then streams LANES-wide words with base/length/repeat/direction control.
module tf_rom_seq #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 213,
  parameter int LANES   = 4,
  parameter int COEF_W  = 21,
  parameter int OUT_REG = 1,
  parameter int REP_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [LANES*COEF_W-1:0]   wr_data,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           len,
  input  logic [REP_W-1:0]          rep,
  input  logic                      dir,
  input  logic                      tf_ready,
  output logic                      tf_valid,
  output logic [LANES*COEF_W-1:0]   tf_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  localparam int WORD_W = LANES * COEF_W;
  localparam int STAGES = 1 + OUT_REG;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic [ADDR_W-1:0] addr, addr_step;
  logic [ADDR_W:0]   wcnt;
  logic [REP_W-1:0]  rep_l, rcnt;
  logic              dir_l;
  logic [STAGES:1]   vld_pipe;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q;
  logic adv, issue, pend, last_acc, last_issue, start_ok, wr_ok, bad_wr, bad_base, addr_ok;

  assign tf_valid   = vld_pipe[STAGES];
  assign adv        = tf_ready | ~tf_valid;
  assign busy       = (state != IDLE);
  assign issue      = (state == RUN) & adv;
  assign start_ok   = (state == IDLE) & start;
  assign wr_ok      = (state == IDLE) & wr_en & ({1'b0, wr_addr} < DEPTH_C);
  assign bad_wr     = wr_en & ((state != IDLE) | ({1'b0, wr_addr} >= DEPTH_C));
  assign bad_base   = {1'b0, base_addr} >= DEPTH_C;
  assign addr_ok    = {1'b0, addr} < DEPTH_C;
  assign last_issue = issue & (rcnt == rep_l) & (wcnt == (ADDR_W+1)'(1));
  // With the output register, a beat may still sit in the RAM stage behind the visible one.
  assign pend       = (OUT_REG != 0) && vld_pipe[1];
  assign last_acc   = (state == DRAIN) & tf_valid & tf_ready & ~pend;

  // Out-of-range addresses fold back into the table on the first step.
  always_comb begin
    addr_step = addr;
    if (dir_l) addr_step = (addr == '0 || !addr_ok) ? LAST_A : addr - 1'b1;
    else       addr_step = (addr >= LAST_A) ? '0 : addr + 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && len != '0) state_n = RUN;
      RUN:     if (last_issue) state_n = DRAIN;
      DRAIN:   if (last_acc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      wcnt     <= '0;
      rep_l    <= '0;
      rcnt     <= '0;
      dir_l    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      vld_pipe <= '0;
    end else begin
      done <= last_acc | (start_ok & (len == '0));
      if (start_ok)    err <= bad_base | bad_wr;
      else if (bad_wr) err <= 1'b1;
      if (start_ok) begin
        addr  <= base_addr;
        wcnt  <= len;
        rep_l <= (rep == '0) ? REP_W'(1) : rep;
        rcnt  <= REP_W'(1);
        dir_l <= dir;
      end else if (issue) begin
        if (rcnt == rep_l) begin
          rcnt <= REP_W'(1);
          wcnt <= wcnt - 1'b1;
          addr <= addr_step;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
      if (adv) begin
        vld_pipe[1] <= issue;
        for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // Single-port RAM: writes only happen in IDLE, reads only in RUN.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        ram_q <= '0;
    else if (issue) ram_q <= addr_ok ? mem[addr] : '0;
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WORD_W-1:0] oreg;
      always_ff @(posedge clk) begin
        if (rst)      oreg <= '0;
        else if (adv) oreg <= ram_q;
      end
      assign tf_data = oreg;
    end else begin : g_noreg
      assign tf_data = ram_q;
    end
  endgenerate
endmodule
